fb_read_arbiter: RTL and testbench
==================================

Name: fb_read_arbiter

Overview:
- Shares the single read port of the 320x240x16-bit two-bank frame buffer between two requesters: the VGA display path (requester A, priority) and the NN feature/downsample reader (requester B).
- Issues a registered read address and tracks in-flight reads with a tag pipeline, so each read datum returns to the requester that issued it.
- Enforces the frame buffer's bank-select constraint: its output mux follows the live rdaddress[16], so the bank bit must not change while a read is in flight.
- Sits between the frame buffer read port and the display/NN clients, in the frame buffer's read clock domain.

Parameters:
- RD_LAT, 2, frame buffer read latency in cycles from rdaddress change to valid q (1..4).
- FB_DEPTH, 76800, number of valid pixel addresses (0..FB_DEPTH-1).
- STARVE_LIMIT, 15, consecutive denied cycles of B before B takes priority over A for one arbitration.

Ports:
- clk  in  1  clock; also drives the frame buffer rdclock.
- rst_n  in  1  asynchronous active-low reset.
- a_req  in  1  display read request.
- a_addr  in  17  display pixel address.
- a_gnt  out  1  display request accepted this cycle (combinational).
- a_rvalid  out  1  a_rdata valid.
- a_rdata  out  16  display read data.
- b_req  in  1  NN read request.
- b_addr  in  17  NN pixel address.
- b_gnt  out  1  NN request accepted this cycle (combinational).
- b_rvalid  out  1  b_rdata valid.
- b_rdata  out  16  NN read data.
- fb_rdaddress  out  17  to frame buffer rdaddress (registered).
- fb_q  in  16  from frame buffer q.
- err_clr  in  1  clears err_oor.
- err_oor  out  1  sticky: an out-of-range address was accepted.
- busy  out  1  at least one read in flight.

Behaviour:
- Reset (async, rst_n=0): fb_rdaddress=0, a_rvalid=b_rvalid=0, a_rdata=b_rdata=0, err_oor=0, busy=0, tag pipeline empty, starvation counter=0. a_gnt and b_gnt are 0 while in reset. Any in-flight reads are discarded and no rvalid follows them.
- Accept = x_req && x_gnt. At most one accept per cycle. The requester holds its addr stable while x_req=1 and x_gnt=0.
- Winner selection: A wins by default. B wins if b_req=1 and either a_req=0 or starve_cnt==STARVE_LIMIT.
- Bank hazard:
  - An in-range winner whose addr[16] differs from fb_rdaddress[16] while busy=1 is not granted.
  - The loser is not granted either in that cycle. No overtaking.
  - The winner is granted in the first cycle busy=0.
- Issue timing:
  - An in-range accept at cycle t loads fb_rdaddress at edge t+1.
  - The tag pipeline entry (requester id, oor=0) matures RD_LAT cycles after that.
  - x_rvalid=1 for one cycle with x_rdata=fb_q. Total accept-to-rvalid = RD_LAT+1 cycles.
- Out-of-range (addr >= FB_DEPTH):
  - The request is accepted. fb_rdaddress is not changed and it is exempt from the bank hazard.
  - It occupies a tag slot with the same RD_LAT+1 timing, returns x_rdata=16'h0000, and sets err_oor.
- Back-to-back accepts are allowed every cycle within the same bank; throughput is 1 read/cycle. Responses return in acceptance order.
- fb_rdaddress holds its last value when idle.
- starve_cnt (4 bits, saturating at STARVE_LIMIT):
  - Increments each cycle b_req=1 and b_gnt=0.
  - Clears on a B accept or when b_req=0.
  - Does not clear while B is hazard-blocked at the limit.
- err_oor: set has priority over err_clr in the same cycle.
- busy = any valid tag entry, including the cycle fb_rdaddress is loaded.
- a_rvalid and b_rvalid are never both 1 in one cycle.

Test Plan:
- Reset then A-only burst: a_addr=0..7 with a_req held → a_gnt=1 for 8 cycles; a_rvalid on cycles 3..10 (RD_LAT=2); a_rdata equals preloaded RAM words 0..7.
- Contention: a_req and b_req held continuously, same bank → A granted 15 cycles, B granted on the 16th, pattern repeats; every b_rvalid matches its b_addr data.
- Bank hazard: A accepts addr 17'h0FFFF, next cycle A requests 17'h10000 → a_gnt=0 for RD_LAT+1 cycles until busy=0, then granted; no corrupted rdata.
- Out-of-range: B requests 76800 and 17'h1FFFF → both accepted, b_rdata=0, err_oor=1, fb_rdaddress unchanged; err_clr pulse → err_oor=0; err_clr coincident with a new OOR accept → err_oor stays 1.
- Reset mid-operation: assert rst_n=0 with 2 reads in flight → no rvalid afterward; all outputs 0; first post-reset read returns at the nominal latency.
- Interleaved A/B stream with random addresses across both banks (1000 reads) → scoreboard: in-order per-requester data, no rvalid overlap, no rdaddress[16] change while busy.

Source files
------------

// File: rtl/fb_read_arbiter.sv
// Two-requester arbiter for the frame buffer read port: display (A) has priority, NN reader (B)
// gets a starvation override; a tag pipeline routes each returning word back to its issuer.
module fb_read_arbiter #(
  parameter int RD_LAT       = 2,
  parameter int FB_DEPTH     = 76800,
  parameter int STARVE_LIMIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_req,
  input  logic [16:0] a_addr,
  output logic        a_gnt,
  output logic        a_rvalid,
  output logic [15:0] a_rdata,
  input  logic        b_req,
  input  logic [16:0] b_addr,
  output logic        b_gnt,
  output logic        b_rvalid,
  output logic [15:0] b_rdata,
  output logic [16:0] fb_rdaddress,
  input  logic [15:0] fb_q,
  input  logic        err_clr,
  output logic        err_oor,
  output logic        busy
);

  localparam int NSTG = RD_LAT + 1;

  logic [NSTG-1:0] tag_vld;
  logic [NSTG-1:0] tag_id;
  logic [NSTG-1:0] tag_oor;
  logic [3:0]      starve_cnt;

  logic        b_win;
  logic [16:0] win_addr;
  logic        win_oor;
  logic        hazard;
  logic        acc;
  logic        out_vld;
  logic        out_id;
  logic        out_oor;

  assign busy = |tag_vld;

  always_comb begin
    b_win    = b_req && (!a_req || (starve_cnt == 4'(STARVE_LIMIT)));
    win_addr = b_win ? b_addr : a_addr;
    win_oor  = win_addr >= 17'(FB_DEPTH);
    // The RAM output mux follows the live bank bit, so a bank switch must wait for a drained pipe.
    hazard   = busy && !win_oor && (win_addr[16] != fb_rdaddress[16]);
    a_gnt    = rst_n && a_req && !b_win && !hazard;
    b_gnt    = rst_n && b_win && !hazard;
    acc      = a_gnt || b_gnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld <= '0;
      tag_id  <= '0;
      tag_oor <= '0;
    end else begin
      tag_vld <= {tag_vld[NSTG-2:0], acc};
      tag_id  <= {tag_id[NSTG-2:0], b_gnt};
      tag_oor <= {tag_oor[NSTG-2:0], acc && win_oor};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_rdaddress <= '0;
    end else if (acc && !win_oor) begin
      fb_rdaddress <= win_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!b_req || b_gnt) begin
      starve_cnt <= '0;
    end else if (starve_cnt != 4'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_oor <= 1'b0;
    end else if (acc && win_oor) begin
      err_oor <= 1'b1;
    end else if (err_clr) begin
      err_oor <= 1'b0;
    end
  end

  always_comb begin
    out_vld  = tag_vld[NSTG-1];
    out_id   = tag_id[NSTG-1];
    out_oor  = tag_oor[NSTG-1];
    a_rvalid = out_vld && !out_id;
    b_rvalid = out_vld && out_id;
    a_rdata  = (a_rvalid && !out_oor) ? fb_q : 16'h0000;
    b_rdata  = (b_rvalid && !out_oor) ? fb_q : 16'h0000;
  end

endmodule

// File: tb/tb_fb_read_arbiter.sv
// Directed bench for fb_read_arbiter with a frame-buffer model whose output mux follows the
// live bank bit, plus an in-order per-requester scoreboard.
module tb_fb_read_arbiter;

  localparam int RD_LAT   = 2;
  localparam int FB_DEPTH = 76800;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, b_req, err_clr;
  logic [16:0] a_addr, b_addr;
  logic        a_gnt, b_gnt, a_rvalid, b_rvalid, err_oor, busy;
  logic [15:0] a_rdata, b_rdata, fb_q;
  logic [16:0] fb_rdaddress;

  int n_cmp = 0;
  int n_err = 0;

  fb_read_arbiter #(.RD_LAT(RD_LAT), .FB_DEPTH(FB_DEPTH), .STARVE_LIMIT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_addr(a_addr), .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_addr(b_addr), .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .fb_rdaddress(fb_rdaddress), .fb_q(fb_q),
    .err_clr(err_clr), .err_oor(err_oor), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] data_of(input logic [16:0] a);
    return a[15:0] ^ (a[16] ? 16'hA5C3 : 16'h3C5A);
  endfunction

  function automatic logic [15:0] exp_data(input logic [16:0] a);
    return (a >= 17'(FB_DEPTH)) ? 16'h0000 : data_of(a);
  endfunction

  // Frame buffer model: word address delayed RD_LAT cycles, bank bit taken live.
  logic [15:0] lo_pipe [RD_LAT];
  always @(posedge clk) begin
    lo_pipe[0] <= fb_rdaddress[15:0];
    for (int k = 1; k < RD_LAT; k++) lo_pipe[k] <= lo_pipe[k-1];
  end
  assign fb_q = data_of({fb_rdaddress[16], lo_pipe[RD_LAT-1]});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [16:0] rnd_addr;
    int r;
    r = $urandom_range(0, 99);
    if (r < 3) return 17'(FB_DEPTH + $urandom_range(0, 1000));
    else if (r < 50) return 17'($urandom_range(0, 65535));
    else return 17'(65536 + $urandom_range(0, FB_DEPTH - 65537));
  endfunction

  logic [15:0] qa [$];
  logic [15:0] qb [$];
  logic        prev_bank = 1'b0;
  logic        prev_busy = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      qa.delete();
      qb.delete();
    end else begin
      if (a_rvalid) begin
        chk("a_rvalid_expected", 32'(qa.size() != 0), 32'd1);
        if (qa.size() != 0) chk("a_rdata_sb", 32'(a_rdata), 32'(qa.pop_front()));
      end
      if (b_rvalid) begin
        chk("b_rvalid_expected", 32'(qb.size() != 0), 32'd1);
        if (qb.size() != 0) chk("b_rdata_sb", 32'(b_rdata), 32'(qb.pop_front()));
      end
      if (a_rvalid || b_rvalid) chk("rvalid_overlap", 32'(a_rvalid && b_rvalid), 32'd0);
      if (fb_rdaddress[16] != prev_bank) chk("bank_change_while_busy", 32'(prev_busy), 32'd0);
      if (a_req && a_gnt) qa.push_back(exp_data(a_addr));
      if (b_req && b_gnt) qb.push_back(exp_data(b_addr));
    end
    prev_bank <= fb_rdaddress[16];
    prev_busy <= busy;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   acc_cnt;
    int   cyc;
    logic a_took, b_took;

    rst_n = 1'b0; a_req = 1'b1; b_req = 1'b1; err_clr = 1'b0;
    a_addr = 17'd3; b_addr = 17'd4;
    @(negedge clk);
    chk("rst_a_gnt", 32'(a_gnt), 32'd0);
    chk("rst_b_gnt", 32'(b_gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdaddr", 32'(fb_rdaddress), 32'd0);
    chk("rst_err", 32'(err_oor), 32'd0);
    chk("rst_rvalid", 32'({a_rvalid, b_rvalid}), 32'd0);
    chk("rst_rdata", 32'({a_rdata, b_rdata}), 32'd0);
    tick;
    a_req = 1'b0; b_req = 1'b0;
    rst_n = 1'b1;
    tick;

    // A-only burst 0..7
    a_req = 1'b1; a_addr = 17'd0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      chk("burst_a_gnt", 32'(a_gnt), 32'(i < 8));
      chk("burst_a_rvalid", 32'(a_rvalid), 32'(i >= 3));
      chk("burst_a_rdata", 32'(a_rdata), (i >= 3) ? 32'(data_of(17'(i - 3))) : 32'd0);
      tick;
      a_addr = 17'(i + 1);
      a_req  = (i + 1) < 8;
    end
    repeat (2) tick;

    // Contention: B gets every 16th slot
    a_req = 1'b1; b_req = 1'b1; a_addr = 17'd100; b_addr = 17'd200;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      chk("cont_a_gnt", 32'(a_gnt), 32'((k % 16) != 15));
      chk("cont_b_gnt", 32'(b_gnt), 32'((k % 16) == 15));
      tick;
      if ((k % 16) == 15) b_addr = b_addr + 17'd1;
      else a_addr = a_addr + 17'd1;
    end
    a_req = 1'b0; b_req = 1'b0;
    repeat (5) tick;

    // Bank hazard
    a_req = 1'b1; a_addr = 17'h0FFFF;
    @(negedge clk);
    chk("hz_first_gnt", 32'(a_gnt), 32'd1);
    tick;
    a_addr = 17'h10000;
    for (int j = 1; j < 5; j++) begin
      @(negedge clk);
      chk("hz_gnt", 32'(a_gnt), 32'(j == 4));
      chk("hz_busy", 32'(busy), 32'(j < 4));
      chk("hz_rdaddr_hold", 32'(fb_rdaddress), 32'h0FFFF);
      tick;
    end
    a_req = 1'b0;
    @(negedge clk);
    chk("hz_rdaddr_new", 32'(fb_rdaddress), 32'h10000);
    repeat (5) tick;

    // Out-of-range reads and err_oor
    b_req = 1'b1; b_addr = 17'(FB_DEPTH);
    @(negedge clk);
    chk("oor_gnt0", 32'(b_gnt), 32'd1);
    chk("oor_err_before", 32'(err_oor), 32'd0);
    tick;
    b_addr = 17'h1FFFF;
    @(negedge clk);
    chk("oor_gnt1", 32'(b_gnt), 32'd1);
    chk("oor_err_set", 32'(err_oor), 32'd1);
    chk("oor_rdaddr", 32'(fb_rdaddress), 32'h10000);
    tick;
    b_req = 1'b0;
    @(negedge clk);
    chk("oor_no_rvalid_yet", 32'(b_rvalid), 32'd0);
    chk("oor_rdaddr2", 32'(fb_rdaddress), 32'h10000);
    tick;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      chk("oor_rvalid", 32'(b_rvalid), 32'd1);
      chk("oor_rdata", 32'(b_rdata), 32'd0);
      tick;
    end
    err_clr = 1'b1;
    @(negedge clk);
    chk("oor_err_held", 32'(err_oor), 32'd1);
    tick;
    err_clr = 1'b0;
    @(negedge clk);
    chk("oor_err_cleared", 32'(err_oor), 32'd0);
    tick;
    err_clr = 1'b1; b_req = 1'b1; b_addr = 17'(FB_DEPTH + 1);
    @(negedge clk);
    chk("oor_coinc_gnt", 32'(b_gnt), 32'd1);
    tick;
    err_clr = 1'b0; b_req = 1'b0;
    @(negedge clk);
    chk("oor_set_over_clr", 32'(err_oor), 32'd1);
    repeat (4) tick;

    // Reset with two reads in flight
    a_req = 1'b1; a_addr = 17'd5;
    @(negedge clk);
    chk("mid_gnt0", 32'(a_gnt), 32'd1);
    tick;
    a_addr = 17'd6;
    tick;
    b_req = 1'b1; b_addr = 17'd7;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_gnt", 32'({a_gnt, b_gnt}), 32'd0);
    chk("mid_rst_rvalid", 32'({a_rvalid, b_rvalid}), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rdaddr", 32'(fb_rdaddress), 32'd0);
    chk("mid_rst_err", 32'(err_oor), 32'd0);
    chk("mid_rst_rdata", 32'(a_rdata), 32'd0);
    tick;
    a_req = 1'b0; b_req = 1'b0; rst_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("mid_no_rvalid", 32'({a_rvalid, b_rvalid}), 32'd0);
      tick;
    end
    a_req = 1'b1; a_addr = 17'd9;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("post_rst_rvalid", 32'(a_rvalid), 32'(j == 3));
      if (j == 3) chk("post_rst_rdata", 32'(a_rdata), 32'(data_of(17'd9)));
      tick;
      a_req = 1'b0;
    end

    // Random interleaved stream across both banks
    acc_cnt = 0; cyc = 0; a_took = 1'b0; b_took = 1'b0;
    while (acc_cnt < 1000 && cyc < 20000) begin
      if (!a_req || a_took) begin
        a_req  = $urandom_range(0, 3) != 0;
        a_addr = rnd_addr();
      end
      if (!b_req || b_took) begin
        b_req  = $urandom_range(0, 1) != 0;
        b_addr = rnd_addr();
      end
      @(negedge clk);
      a_took  = a_req && a_gnt;
      b_took  = b_req && b_gnt;
      acc_cnt += int'(a_took) + int'(b_took);
      tick;
      cyc++;
    end
    chk("rand_accept_count", 32'(acc_cnt >= 1000), 32'd1);
    a_req = 1'b0; b_req = 1'b0;
    repeat (6) tick;
    chk("sb_drained", 32'(qa.size() + qb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
